bit_serial_adder: RTL and testbench

Bit-serial N-bit adder controller that sequences a single NAND-built full-adder cell over WIDTH clock cycles. It latches two operands and a carry-in on a start request, then feeds one bit pair per cycle (LSB first) through the cell with a registered carry. It returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requesting control unit and the gate-level adder cell, trading latency for a one-cell datapath.

---
 rtl/bit_serial_pkg.sv | 15 +
 rtl/fa_nand_cell.sv | 23 ++
 rtl/bit_serial_adder.sv | 135 +++++++++++++
 tb/tb_bit_serial_adder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// rtl/bit_serial_pkg.sv - shared types and sizing helpers for the bit-serial adder
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must index 0..width-1; a 1-bit counter is kept even for width 1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fa_nand_cell.sv
// rtl/fa_nand_cell.sv - one-bit full adder built only from two-input NAND gates
module fa_nand_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic n1, n2, n3, axb, n4, n5, n6;

    // Classic nine-gate form: first half-adder yields a^b, second folds in cin.
    assign n1   = ~(a & b);
    assign n2   = ~(a & n1);
    assign n3   = ~(b & n1);
    assign axb  = ~(n2 & n3);
    assign n4   = ~(axb & cin);
    assign n5   = ~(axb & n4);
    assign n6   = ~(cin & n4);
    assign sum  = ~(n5 & n6);
    assign cout = ~(n1 & n4);

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - sequences one NAND full-adder cell over WIDTH cycles, LSB first
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             run;
    logic             last;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CW-1:0]    count;
    logic             cell_sum;
    logic             cell_cout;

    fa_nand_cell u_cell (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign run  = (state == RUN);
    assign last = (count == CW'(WIDTH - 1));

    // The low result bit is already in place once shifted in, so the partial-sum
    // register only needs WIDTH-1 bits; the cell output supplies the top bit.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_next = cell_sum;
        end else begin : g_wn
            logic [WIDTH-2:0] shift_s;

            assign sum_next = {cell_sum, shift_s};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shift_s <= '0;
                end else if (accept) begin
                    shift_s <= '0;
                end else if (run) begin
                    shift_s <= sum_next[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            carry   <= 1'b0;
            count   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            shift_a <= op_a;
            shift_b <= op_b;
            carry   <= cin;
            count   <= '0;
        end else if (run) begin
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            carry   <= cell_cout;
            if (last) begin
                sum_q  <= sum_next;
                cout_q <= cell_cout;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign busy = run;
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - scoreboard bench for the bit-serial adder (WIDTH 8 and 1)
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .op_a  (a1),
        .op_b  (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = c;
        exp_q.push_back(9'(a) + 9'(b) + 9'(c));
    endtask

    // Runs from the start cycle until done or a 40-cycle budget, reporting what was seen.
    task automatic collect(output logic [8:0] got, output int lat, output int nbusy,
                           output bit overlap, output bit seen);
        lat = 0; nbusy = 0; overlap = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (busy && done) overlap = 1'b1;
            if (busy) nbusy++;
        end while (!done && lat < 40);
        seen = done;
        got  = {cout, sum};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        n_cmp++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_w8: busy/done/cout/sum=%b want 0", {busy, done, cout, sum});
        end
        n_cmp++;
        if ({busy1, done1, cout1, sum1} !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_w1: busy/done/cout/sum=%b want 0", {busy1, done1, cout1, sum1});
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_zero;
        logic [8:0] got, ex;
        int lat, nb;
        bit ov, seen;
        issue(8'h00, 8'h00, 1'b0);
        collect(got, lat, nb, ov, seen);
        ex = exp_q.pop_front();
        n_cmp++;
        if (!seen || lat !== 9) begin
            n_bad++;
            $display("FAIL zero_latency: done cycle %0d (seen=%0d) want 9", lat, seen);
        end
        n_cmp++;
        if (nb !== 8 || ov) begin
            n_bad++;
            $display("FAIL zero_busy: busy cycles %0d overlap %0d want 8/0", nb, ov);
        end
        n_cmp++;
        if (got !== ex) begin
            n_bad++;
            $display("FAIL zero_result: got %h want %h", got, ex);
        end
        idle(2);
    endtask

    task automatic test_ripple;
        logic [16:0] vec[2] = '{{8'hFF, 8'h01, 1'b0}, {8'hA5, 8'h5A, 1'b1}};
        logic [8:0] got, ex;
        int lat, nb;
        bit ov, seen;
        for (int i = 0; i < 2; i++) begin
            issue(vec[i][16:9], vec[i][8:1], vec[i][0]);
            collect(got, lat, nb, ov, seen);
            ex = exp_q.pop_front();
            n_cmp++;
            if (!seen || lat !== 9 || nb !== 8 || ov) begin
                n_bad++;
                $display("FAIL ripple_timing[%0d]: done %0d busy %0d overlap %0d want 9/8/0", i, lat, nb, ov);
            end
            n_cmp++;
            if (got !== ex || ex !== 9'h100) begin
                n_bad++;
                $display("FAIL ripple_result[%0d]: got %h want %h", i, got, ex);
            end
            idle(2);
        end
    endtask

    task automatic test_ignored_start;
        logic [8:0] got, ex;
        int ndone = 0, done_cyc = -1, nb = 0, late_busy = 0;
        issue(8'h12, 8'h34, 1'b0);
        ex = exp_q.pop_front();
        got = 'x;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) start = 1'b0;
            if (busy) nb++;
            if (busy && cyc > 9) late_busy++;
            if (done) begin
                ndone++;
                done_cyc = cyc;
                got = {cout, sum};
            end
            if (cyc == 4) begin
                start = 1'b1;
                op_a  = 8'hFF;
            end
            if (cyc == 5) start = 1'b0;
        end
        n_cmp++;
        if (ndone !== 1 || done_cyc !== 9) begin
            n_bad++;
            $display("FAIL ignored_done: %0d dones, last cycle %0d, want 1 at 9", ndone, done_cyc);
        end
        n_cmp++;
        if (nb !== 8 || late_busy !== 0) begin
            n_bad++;
            $display("FAIL ignored_busy: busy %0d late %0d want 8/0", nb, late_busy);
        end
        n_cmp++;
        if (got !== ex || {cout, sum} !== ex) begin
            n_bad++;
            $display("FAIL ignored_result: got %h held %h want %h", got, {cout, sum}, ex);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] ex;
        int dc[$];
        int hold_err = 0;
        issue(8'h10, 8'h20, 1'b0);
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc >= 9 && cyc <= 17 && {cout, sum} !== 9'h030) hold_err++;
            if (done) begin
                dc.push_back(cyc);
                ex = exp_q.pop_front();
                n_cmp++;
                if ({cout, sum} !== ex) begin
                    n_bad++;
                    $display("FAIL b2b_result@%0d: got %h want %h", cyc, {cout, sum}, ex);
                end
            end
            if (cyc == 9) issue(8'h80, 8'h80, 1'b0);
            if (cyc == 10) start = 1'b0;
        end
        n_cmp++;
        if (dc.size() !== 2 || dc[0] !== 9 || dc[1] !== 18) begin
            n_bad++;
            $display("FAIL b2b_done_cycles: count %0d first %0d second %0d want 9,18",
                     dc.size(), (dc.size() > 0) ? dc[0] : -1, (dc.size() > 1) ? dc[1] : -1);
        end
        n_cmp++;
        if (hold_err !== 0) begin
            n_bad++;
            $display("FAIL b2b_hold: sum left 0x30 in %0d of cycles 9..17", hold_err);
        end
    endtask

    task automatic test_reset_mid;
        logic [8:0] got, ex;
        int lat, nb;
        bit ov, seen;
        start = 1'b1; op_a = 8'h0F; op_b = 8'h01; cin = 1'b0;
        idle(1);
        start = 1'b0;
        idle(3);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: busy/done/cout/sum=%b want 0", {busy, done, cout, sum});
        end
        idle(1);
        rst = 1'b0;
        idle(1);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_idle: busy %b done %b want 0 0", busy, done);
        end
        issue(8'h03, 8'h04, 1'b0);
        collect(got, lat, nb, ov, seen);
        ex = exp_q.pop_front();
        n_cmp++;
        if (!seen || lat !== 9 || nb !== 8 || got !== ex) begin
            n_bad++;
            $display("FAIL midreset_fresh: done %0d busy %0d got %h want 9/8/%h", lat, nb, got, ex);
        end
        idle(2);
    endtask

    task automatic test_width1;
        logic [1:0] ex;
        int cyc, nb;
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
            start1 = 1'b1;
            exp1_q.push_back(2'(a1) + 2'(b1) + 2'(cin1));
            cyc = 0; nb = 0;
            do begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == 1) start1 = 1'b0;
                if (busy1) nb++;
            end while (!done1 && cyc < 10);
            ex = exp1_q.pop_front();
            n_cmp++;
            if (!done1 || cyc !== 2 || nb !== 1 || {cout1, sum1} !== ex) begin
                n_bad++;
                $display("FAIL w1[%0d]: done cycle %0d busy %0d got %b want 2/1/%b", i, cyc, nb, {cout1, sum1}, ex);
            end
            idle(1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset;
        test_zero;
        test_ripple;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        test_width1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
